instr_predecode: RTL and testbench

- Upstream neighbour of the opcode-to-control FSM.
- Latches the opcode byte from the data bus on the fetch cycle and classifies it as NORM, RMW or BRANCH.
- Handles the 6502 interrupt sources (RESET, NMI, IRQ). When one is taken, it substitutes a forced BRK (8'h00) for the fetched opcode and reports which vector to use.
- Generates the FSM's active-high reset, stretched past the release of the external reset.

---
 rtl/instr_predecode_pkg.sv | 52 +++++
 rtl/instr_predecode_if.sv | 27 ++
 rtl/instr_predecode_pin_sync.sv | 24 ++
 rtl/instr_predecode.sv | 114 +++++++++++
 tb/tb_instr_predecode.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_predecode_pkg.sv
// Shared encodings, payload type and opcode classifier for the opcode predecoder.
package predecode_defs;

    localparam int unsigned OPCODE_W   = 8;
    localparam int unsigned HOLD_W     = 4;
    localparam int unsigned I_FLAG_BIT = 2;

    localparam logic [OPCODE_W-1:0] BRK_OPCODE = 8'h00;

    typedef enum logic [1:0] {
        NORM   = 2'd0,
        RMW    = 2'd1,
        BRANCH = 2'd2
    } instr_class_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IRQ  = 2'd1,
        NMI  = 2'd2,
        RST  = 2'd3
    } int_type_e;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_HOLD  = 2'd1,
        S_RUN   = 2'd2,
        S_INT   = 2'd3
    } state_e;

    // Everything the predecoder presents to the control FSM, registered as one unit.
    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        instr_class_e        cls;
        logic                force_brk;
        int_type_e           int_type;
    } predecode_out_t;

    // Column/row classification of a 6502 opcode; BRK (00) falls out as NORM.
    function automatic instr_class_e classify(input logic [OPCODE_W-1:0] op);
        instr_class_e cls;
        cls = NORM;
        if (op[4:0] == 5'b10000) begin
            cls = BRANCH;
        end else if ((op[1:0] == 2'b10) &&
                     (op[7:5] inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111}) &&
                     (op[4:2] inside {3'b001, 3'b011, 3'b101, 3'b111})) begin
            cls = RMW;
        end
        return cls;
    endfunction

endpackage

// File: rtl/instr_predecode_if.sv
// Bus between the predecoder (slave) and the CPU core / control FSM side (master).
interface instr_predecode_if;

    logic       RDY;
    logic       SYNC;
    logic [7:0] dataIn;
    logic [7:0] statusReg;
    logic       nNMI;
    logic       nIRQ;
    logic       intAck;
    logic [7:0] opcode;
    logic [1:0] instrClass;
    logic       forceBRK;
    logic [1:0] intType;
    logic       resetFSM;

    modport master (
        output RDY, SYNC, dataIn, statusReg, nNMI, nIRQ, intAck,
        input  opcode, instrClass, forceBRK, intType, resetFSM
    );

    modport slave (
        input  RDY, SYNC, dataIn, statusReg, nNMI, nIRQ, intAck,
        output opcode, instrClass, forceBRK, intType, resetFSM
    );

endinterface

// File: rtl/instr_predecode_pin_sync.sv
// Multi-flop synchroniser for an asynchronous active-low pin; idles high.
module pin_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic q
);

    logic [STAGES-1:0] sr;

    // Shift the pin through the chain; reset parks it at the inactive level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr <= '1;
        end else begin
            sr <= {sr[STAGES-2:0], pin};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/instr_predecode.sv
// Opcode latch, class decode, interrupt substitution and stretched FSM reset.
module instr_predecode
    import predecode_defs::*;
#(
    parameter int unsigned RESET_HOLD  = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               phi1,
    input  logic               resetN,
    instr_predecode_if.slave   bus
);

    state_e         state;
    logic [HOLD_W-1:0] hold_cnt;
    logic           nmi_pending;
    logic           nmi_d;
    logic           reset_fsm;
    predecode_out_t out_q;

    logic nmi_s;
    logic irq_s;
    logic fetch_c;
    logic nmi_fall_c;
    logic nmi_ack_c;
    logic irq_take_c;
    instr_class_e fetch_cls_c;

    pin_sync #(.STAGES(SYNC_STAGES)) u_nmi_sync (
        .clk   (phi1),
        .rst_n (resetN),
        .pin   (bus.nNMI),
        .q     (nmi_s)
    );

    pin_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
        .clk   (phi1),
        .rst_n (resetN),
        .pin   (bus.nIRQ),
        .q     (irq_s)
    );

    // Qualifiers for the current edge: fetch, NMI edge, NMI retirement, IRQ acceptance.
    always_comb begin
        fetch_c     = bus.SYNC & bus.RDY;
        nmi_fall_c  = nmi_d & ~nmi_s;
        nmi_ack_c   = (state == S_INT) && bus.intAck && (out_q.int_type == NMI);
        irq_take_c  = ~irq_s & ~bus.statusReg[I_FLAG_BIT];
        fetch_cls_c = classify(bus.dataIn);
    end

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge phi1) begin
        if (!resetN) begin
            state       <= S_RESET;
            hold_cnt    <= '0;
            nmi_pending <= 1'b0;
            nmi_d       <= 1'b1;
            reset_fsm   <= 1'b1;
            out_q       <= '{opcode: BRK_OPCODE, cls: NORM, force_brk: 1'b1, int_type: RST};
        end else begin
            nmi_d <= nmi_s;

            // A fresh edge outranks the acknowledge that would retire the old one.
            if (nmi_fall_c) begin
                nmi_pending <= 1'b1;
            end else if (nmi_ack_c) begin
                nmi_pending <= 1'b0;
            end

            case (state)
                S_RESET: begin
                    state    <= S_HOLD;
                    hold_cnt <= HOLD_W'(RESET_HOLD - 1);
                end
                S_HOLD: begin
                    if (hold_cnt == '0) begin
                        state     <= S_INT;
                        reset_fsm <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    if (fetch_c) begin
                        if (nmi_pending) begin
                            out_q <= '{opcode: BRK_OPCODE, cls: NORM, force_brk: 1'b1, int_type: NMI};
                            state <= S_INT;
                        end else if (irq_take_c) begin
                            out_q <= '{opcode: BRK_OPCODE, cls: NORM, force_brk: 1'b1, int_type: IRQ};
                            state <= S_INT;
                        end else begin
                            out_q <= '{opcode: bus.dataIn, cls: fetch_cls_c, force_brk: 1'b0, int_type: NONE};
                        end
                    end
                end
                S_INT: begin
                    if (bus.intAck) begin
                        out_q.force_brk <= 1'b0;
                        out_q.int_type  <= NONE;
                        state           <= S_RUN;
                    end
                end
                default: state <= S_RESET;
            endcase
        end
    end

    assign bus.opcode     = out_q.opcode;
    assign bus.instrClass = out_q.cls;
    assign bus.forceBRK   = out_q.force_brk;
    assign bus.intType    = out_q.int_type;
    assign bus.resetFSM   = reset_fsm;

endmodule

// File: tb/tb_instr_predecode.sv
// Self-checking bench for instr_predecode: vector table plus interrupt sequences.
module tb_instr_predecode;

    localparam logic [1:0] C_NORM = 2'd0, C_RMW = 2'd1, C_BRANCH = 2'd2;
    localparam logic [1:0] T_NONE = 2'd0, T_IRQ = 2'd1, T_NMI = 2'd2, T_RST = 2'd3;

    typedef struct {
        logic [7:0] op;
        logic [1:0] cls;
        logic       fbrk;
        logic [1:0] it;
    } exp_t;

    typedef struct {
        logic [7:0] din;
        logic [1:0] cls;
    } vec_t;

    logic phi1;
    logic resetN;
    int   total;
    int   passed;
    exp_t sb[$];
    vec_t vecs[16];

    instr_predecode_if bus();

    instr_predecode #(.RESET_HOLD(2), .SYNC_STAGES(2)) dut (
        .phi1   (phi1),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    initial phi1 = 1'b0;
    always #5 phi1 = ~phi1;

    task automatic step();
        @(posedge phi1);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic sb_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL %s: scoreboard empty, got opcode %0h expected an entry", name, bus.opcode);
        end else begin
            e = sb.pop_front();
            check({name, " opcode"},   32'(bus.opcode),     32'(e.op));
            check({name, " class"},    32'(bus.instrClass), 32'(e.cls));
            check({name, " forceBRK"}, 32'(bus.forceBRK),   32'(e.fbrk));
            check({name, " intType"},  32'(bus.intType),    32'(e.it));
        end
    endtask

    task automatic fetch(input logic [7:0] din, input exp_t e, input string name);
        bus.SYNC   = 1'b1;
        bus.RDY    = 1'b1;
        bus.dataIn = din;
        sb.push_back(e);
        step();
        bus.SYNC = 1'b0;
        sb_check(name);
    endtask

    task automatic ack();
        bus.intAck = 1'b1;
        step();
        bus.intAck = 1'b0;
    endtask

    initial begin
        total  = 0;
        passed = 0;

        vecs[0]  = '{8'hA9, C_NORM};
        vecs[1]  = '{8'h0E, C_RMW};
        vecs[2]  = '{8'hD0, C_BRANCH};
        vecs[3]  = '{8'h06, C_RMW};
        vecs[4]  = '{8'h8E, C_NORM};
        vecs[5]  = '{8'hAE, C_NORM};
        vecs[6]  = '{8'hEE, C_RMW};
        vecs[7]  = '{8'h1E, C_RMW};
        vecs[8]  = '{8'h0A, C_NORM};
        vecs[9]  = '{8'h4C, C_NORM};
        vecs[10] = '{8'h10, C_BRANCH};
        vecs[11] = '{8'h3E, C_RMW};
        vecs[12] = '{8'hFE, C_RMW};
        vecs[13] = '{8'h02, C_NORM};
        vecs[14] = '{8'h96, C_NORM};
        vecs[15] = '{8'hF0, C_BRANCH};

        resetN        = 1'b0;
        bus.RDY       = 1'b1;
        bus.SYNC      = 1'b0;
        bus.dataIn    = 8'h00;
        bus.statusReg = 8'h04;
        bus.nNMI      = 1'b1;
        bus.nIRQ      = 1'b1;
        bus.intAck    = 1'b0;

        // Reset values and stretched FSM reset.
        repeat (3) step();
        check("rst opcode",   32'(bus.opcode),     32'h00);
        check("rst class",    32'(bus.instrClass), 32'(C_NORM));
        check("rst forceBRK", 32'(bus.forceBRK),   32'd1);
        check("rst intType",  32'(bus.intType),    32'(T_RST));
        check("rst resetFSM", 32'(bus.resetFSM),   32'd1);
        resetN = 1'b1;
        step();
        check("hold1 resetFSM", 32'(bus.resetFSM), 32'd1);
        step();
        check("hold2 resetFSM", 32'(bus.resetFSM), 32'd1);
        check("hold2 intType",  32'(bus.intType),  32'(T_RST));
        step();
        check("hold3 resetFSM", 32'(bus.resetFSM), 32'd0);
        check("hold3 intType",  32'(bus.intType),  32'(T_RST));
        check("hold3 forceBRK", 32'(bus.forceBRK), 32'd1);
        bus.SYNC   = 1'b1;
        bus.dataIn = 8'hA9;
        step();
        bus.SYNC = 1'b0;
        check("int frozen opcode", 32'(bus.opcode), 32'h00);
        ack();
        check("rst ack intType",  32'(bus.intType),  32'(T_NONE));
        check("rst ack forceBRK", 32'(bus.forceBRK), 32'd0);

        // Table of plain fetches.
        for (int i = 0; i < 16; i++) begin
            fetch(vecs[i].din, '{vecs[i].din, vecs[i].cls, 1'b0, T_NONE}, $sformatf("vec%0d", i));
        end

        // RDY stall holds the latch while dataIn wanders.
        fetch(8'h4C, '{8'h4C, C_NORM, 1'b0, T_NONE}, "pre-stall");
        bus.SYNC = 1'b1;
        bus.RDY  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.dataIn = 8'(8'h11 * (i + 1));
            step();
            check($sformatf("stall%0d opcode", i), 32'(bus.opcode), 32'h4C);
        end
        bus.SYNC = 1'b0;
        fetch(8'hEE, '{8'hEE, C_RMW, 1'b0, T_NONE}, "post-stall");

        // IRQ masked by I, then taken with I clear.
        bus.nIRQ = 1'b0;
        repeat (3) step();
        bus.statusReg = 8'h04;
        fetch(8'hA9, '{8'hA9, C_NORM, 1'b0, T_NONE}, "irq masked");
        bus.statusReg = 8'h00;
        fetch(8'h0E, '{8'h00, C_NORM, 1'b1, T_IRQ}, "irq taken");
        ack();
        check("irq ack intType", 32'(bus.intType), 32'(T_NONE));
        bus.nIRQ = 1'b1;
        repeat (3) step();

        // NMI outranks IRQ; a held-low nNMI does not retrigger.
        bus.nIRQ = 1'b0;
        bus.nNMI = 1'b0;
        repeat (4) step();
        fetch(8'hA9, '{8'h00, C_NORM, 1'b1, T_NMI}, "nmi prio");
        ack();
        check("nmi ack intType", 32'(bus.intType), 32'(T_NONE));
        fetch(8'hA9, '{8'h00, C_NORM, 1'b1, T_IRQ}, "irq after nmi");
        ack();
        bus.nIRQ = 1'b1;
        repeat (3) step();

        // New NMI edge lands on the same posedge as the NMI acknowledge.
        bus.nNMI = 1'b1;
        repeat (3) step();
        bus.nNMI = 1'b0;
        repeat (4) step();
        fetch(8'h4C, '{8'h00, C_NORM, 1'b1, T_NMI}, "nmi first");
        bus.nNMI = 1'b1;
        repeat (4) step();
        bus.nNMI = 1'b0;
        step();
        step();
        ack();
        check("coll ack intType", 32'(bus.intType), 32'(T_NONE));
        fetch(8'hA9, '{8'h00, C_NORM, 1'b1, T_NMI}, "nmi again");
        ack();
        fetch(8'hA9, '{8'hA9, C_NORM, 1'b0, T_NONE}, "nmi retired");

        // Reset mid-operation aborts immediately.
        resetN = 1'b0;
        step();
        check("midrst opcode",   32'(bus.opcode),     32'h00);
        check("midrst class",    32'(bus.instrClass), 32'(C_NORM));
        check("midrst forceBRK", 32'(bus.forceBRK),   32'd1);
        check("midrst intType",  32'(bus.intType),    32'(T_RST));
        check("midrst resetFSM", 32'(bus.resetFSM),   32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
